// File: rtl/obstacle_scheduler_if.sv
// Game-event inputs and slot/speed outputs of obstacle_scheduler.
// pause_btn is present only when SCHED_PAUSE_EN is defined.
interface obstacle_scheduler_if;
    logic       game_tick;
    logic       game_start_pulse;
    logic       game_over_pulse;
    logic [7:0] rng;
    logic [8:0] obstacle1_pos;
    logic [8:0] obstacle2_pos;
    logic [2:0] obstacle1_type;
    logic [2:0] obstacle2_type;
    logic [2:0] speed;
    logic       spawn_pulse;
`ifdef SCHED_PAUSE_EN
    logic       pause_btn;

    modport master (
        output game_tick, game_start_pulse, game_over_pulse, rng, pause_btn,
        input  obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, speed, spawn_pulse
    );
    modport slave (
        input  game_tick, game_start_pulse, game_over_pulse, rng, pause_btn,
        output obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, speed, spawn_pulse
    );
`else
    modport master (
        output game_tick, game_start_pulse, game_over_pulse, rng,
        input  obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, speed, spawn_pulse
    );
    modport slave (
        input  game_tick, game_start_pulse, game_over_pulse, rng,
        output obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, speed, spawn_pulse
    );
`endif
endinterface

// File: rtl/obstacle_scheduler.sv
// Two-slot obstacle sequencer: spawn timing, type pick, scrolling and speed ramp, advanced
// once per game_tick enable. Define SCHED_PAUSE_EN to add the pause_btn toggle and PAUSED state.
module obstacle_scheduler #(
    parameter int GEN_LINE   = 250,
    parameter int MIN_GAP    = 40,
    parameter int SPEED_MAX  = 4,
    parameter int RAMP_TICKS = 600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_scheduler_if.slave  bus
);
    localparam int                RAMP_W    = $clog2(RAMP_TICKS + 1);
    localparam logic [8:0]        GEN_POS   = 9'(GEN_LINE);
    localparam logic [7:0]        GAP_MIN   = 8'(MIN_GAP);
    localparam logic [2:0]        SPD_MAX   = 3'(SPEED_MAX);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS);

`ifdef SCHED_PAUSE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN, S_PAUSED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;
`endif

    state_t            r_state, w_state;
    logic [8:0]        r_pos1, r_pos2, w_pos1, w_pos2;
    logic [2:0]        r_type1, r_type2, w_type1, w_type2;
    logic [2:0]        r_speed, w_speed;
    logic              r_spawn, w_spawn;
    logic [7:0]        r_gap, w_gap;
    logic [RAMP_W-1:0] r_ramp, w_ramp;

    logic [8:0]        w_spd9;
    logic [2:0]        w_new_type;
    logic [8:0]        w_mv_pos1, w_mv_pos2, w_tk_pos1, w_tk_pos2;
    logic [2:0]        w_mv_type1, w_mv_type2, w_tk_type1, w_tk_type2;
    logic [7:0]        w_tk_gap;
    logic              w_tk_spawn;
    logic [RAMP_W-1:0] w_tk_ramp;
    logic [2:0]        w_tk_speed;

    assign w_spd9     = {6'd0, r_speed};
    assign w_new_type = {1'b0, bus.rng[1:0]} + 3'd1;

`ifdef SCHED_PAUSE_EN
    logic r_pause_d;
    logic w_pause_rise;
    assign w_pause_rise = bus.pause_btn & ~r_pause_d;
`endif

    // One tick of RUN: move with the pre-tick speed, then spawn on post-move occupancy
    always_comb begin
        w_mv_pos1  = r_pos1;
        w_mv_type1 = r_type1;
        w_mv_pos2  = r_pos2;
        w_mv_type2 = r_type2;
        if (r_type1 != 3'd0) begin
            if (r_pos1 >= w_spd9) begin
                w_mv_pos1 = r_pos1 - w_spd9;
            end else begin
                w_mv_pos1  = '0;
                w_mv_type1 = '0;
            end
        end
        if (r_type2 != 3'd0) begin
            if (r_pos2 >= w_spd9) begin
                w_mv_pos2 = r_pos2 - w_spd9;
            end else begin
                w_mv_pos2  = '0;
                w_mv_type2 = '0;
            end
        end

        w_tk_pos1  = w_mv_pos1;
        w_tk_type1 = w_mv_type1;
        w_tk_pos2  = w_mv_pos2;
        w_tk_type2 = w_mv_type2;
        w_tk_gap   = (r_gap != 8'd0) ? (r_gap - 8'd1) : r_gap;
        w_tk_spawn = 1'b0;
        if ((r_gap == 8'd0) && ((w_mv_type1 == 3'd0) || (w_mv_type2 == 3'd0))) begin
            w_tk_spawn = 1'b1;
            w_tk_gap   = GAP_MIN + {2'b00, bus.rng[7:2]};
            if (w_mv_type1 == 3'd0) begin
                w_tk_pos1  = GEN_POS;
                w_tk_type1 = w_new_type;
            end else begin
                w_tk_pos2  = GEN_POS;
                w_tk_type2 = w_new_type;
            end
        end

        w_tk_ramp  = r_ramp + RAMP_W'(1);
        w_tk_speed = r_speed;
        if (w_tk_ramp == RAMP_LAST) begin
            w_tk_ramp = '0;
            if (r_speed < SPD_MAX) begin
                w_tk_speed = r_speed + 3'd1;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_pos1  = r_pos1;
        w_pos2  = r_pos2;
        w_type1 = r_type1;
        w_type2 = r_type2;
        w_speed = r_speed;
        w_gap   = r_gap;
        w_ramp  = r_ramp;
        w_spawn = 1'b0;
        case (r_state)
            S_IDLE, S_FROZEN: begin
                if (bus.game_start_pulse && !bus.game_over_pulse) begin
                    w_state = S_RUN;
                    w_pos1  = '0;
                    w_pos2  = '0;
                    w_type1 = '0;
                    w_type2 = '0;
                    w_speed = 3'd1;
                    w_gap   = GAP_MIN;
                    w_ramp  = '0;
                end
            end
            S_RUN: begin
                if (bus.game_over_pulse) begin
                    w_state = S_FROZEN;
                end else if (bus.game_start_pulse) begin
                    w_state = S_RUN;
`ifdef SCHED_PAUSE_EN
                end else if (w_pause_rise) begin
                    w_state = S_PAUSED;
`endif
                end else if (bus.game_tick) begin
                    w_pos1  = w_tk_pos1;
                    w_pos2  = w_tk_pos2;
                    w_type1 = w_tk_type1;
                    w_type2 = w_tk_type2;
                    w_speed = w_tk_speed;
                    w_gap   = w_tk_gap;
                    w_ramp  = w_tk_ramp;
                    w_spawn = w_tk_spawn;
                end
            end
`ifdef SCHED_PAUSE_EN
            S_PAUSED: begin
                if (bus.game_over_pulse) begin
                    w_state = S_FROZEN;
                end else if (w_pause_rise) begin
                    w_state = S_RUN;
                end
            end
`endif
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pos1  <= '0;
            r_pos2  <= '0;
            r_type1 <= '0;
            r_type2 <= '0;
            r_speed <= '0;
            r_spawn <= 1'b0;
            r_gap   <= '0;
            r_ramp  <= '0;
        end else begin
            r_state <= w_state;
            r_pos1  <= w_pos1;
            r_pos2  <= w_pos2;
            r_type1 <= w_type1;
            r_type2 <= w_type2;
            r_speed <= w_speed;
            r_spawn <= w_spawn;
            r_gap   <= w_gap;
            r_ramp  <= w_ramp;
        end
    end

`ifdef SCHED_PAUSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause_d <= 1'b0;
        end else begin
            r_pause_d <= bus.pause_btn;
        end
    end
`endif

    assign bus.obstacle1_pos  = r_pos1;
    assign bus.obstacle2_pos  = r_pos2;
    assign bus.obstacle1_type = r_type1;
    assign bus.obstacle2_type = r_type2;
    assign bus.speed          = r_speed;
    assign bus.spawn_pulse    = r_spawn;
endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Single-clock controller that sequences the two obstacle slots feeding obs_render: spawn timing, obstacle type selection, scrolling and speed ramp. It replaces the free-running obstacles block, which is clocked by the 60 Hz tick. This block runs on clk and treats game_tick_60hz as a one-cycle enable. Game flow follows the player_controller start/over pulses.

Parameters:
GEN_LINE, 250, x position (hpos units after CONV) at which a new obstacle spawns
MIN_GAP, 40, minimum ticks between spawns
SPEED_MAX, 4, maximum scroll speed in pixels/tick (fits in 3 bits)
RAMP_TICKS, 600, RUN ticks per speed increment

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
game_tick  in  1  60 Hz enable pulse, one clk wide
game_start_pulse  in  1  one-cycle start from player_controller
game_over_pulse  in  1  one-cycle crash/over from player_controller
rng  in  8  LFSR value, sampled only on spawn
obstacle1_pos  out  9  slot 1 x position
obstacle2_pos  out  9  slot 2 x position
obstacle1_type  out  3  slot 1 type; 0 = empty
obstacle2_type  out  3  slot 2 type; 0 = empty
speed  out  3  current scroll speed
spawn_pulse  out  1  one-cycle pulse on each spawn (for audio/score hooks)

Behaviour:
- Reset (async, rst_n low): state IDLE, all pos/type = 0, speed = 0, spawn_pulse = 0, gap counter = 0, ramp counter = 0. All outputs are registered.
- States: IDLE, RUN, FROZEN.
- IDLE/FROZEN + game_start_pulse -> RUN next cycle:
  - clear both slots to pos 0, type 0
  - speed = 1, gap counter = MIN_GAP, ramp counter = 0.
- RUN + game_over_pulse -> FROZEN. Slots, speed and counters hold, so the crash scene stays on screen.
- Priority when events coincide in one cycle: game_over > game_start > game_tick. A tick arriving with either pulse is ignored.
- game_start_pulse while in RUN: ignored.
- Per game_tick in RUN, all updates take effect in the same registered update (latency 1 clk after the tick):
  1. Move: each occupied slot with pos >= speed gets pos -= speed. An occupied slot with pos < speed is cleared (type 0, pos 0). No negative wrap.
  2. Gap: if gap counter > 0, decrement it.
  3. Spawn: evaluated using the post-move occupancy. A slot freed this tick may be refilled on the same tick.
     - Condition: gap counter is 0 before this tick's decrement, and at least one slot is free.
     - Action: load the lowest-numbered free slot with pos = GEN_LINE and type = rng[1:0] + 1 (range 1..4). Reload gap = MIN_GAP + rng[7:2] (range MIN_GAP..MIN_GAP+63). Assert spawn_pulse for one clk.
     - If both slots are occupied, the gap counter holds at 0 and the spawn happens on the first tick a slot is free.
  4. Ramp: ramp counter increments. On reaching RAMP_TICKS it resets to 0 and speed increments, saturating at SPEED_MAX.
- The new speed applies from the next tick; step 1 always uses the pre-tick speed.
- Widths:
  - pos arithmetic is 9-bit unsigned.
  - The gap counter is 8 bits; MIN_GAP+63 must be <= 255.
  - The ramp counter is sized by $clog2(RAMP_TICKS+1).
- No state changes occur between ticks except the start/over transitions.

Optional Feature:
SCHED_PAUSE_EN. When defined:
- Adds input port pause_btn (1 bit, debounced level) and state PAUSED.
- A rising edge of pause_btn in RUN moves to PAUSED; a rising edge in PAUSED returns to RUN.
- In PAUSED, ticks are ignored and all registers hold.
- game_over_pulse in PAUSED moves to FROZEN.
- game_start_pulse in PAUSED is ignored.
When not defined: no pause_btn port, no PAUSED state, behaviour exactly as above.

Test Plan:
- Reset test: assert rst_n=0 mid-RUN with slots occupied -> outputs go to 0 immediately without a clock. After release the block stays in IDLE; ticks cause no movement and no spawn.
- Start and first spawn: start pulse, then ticks with rng=8'h00.
  - Expected on tick 41 (gap reaches 0 after 40 ticks): slot1 pos=250, type=1, spawn_pulse high for 1 clk, gap reload 40.
  - Expected on the next tick: slot1 pos=249.
- Despawn and lowest-free fill: force speed 4 (via the ramp) with slot1 pos=3 on a tick -> slot1 cleared. If gap=0 and slot2 is occupied, slot1 is reloaded to 250 on that same tick.
- Both slots full: occupy both slots and let gap reach 0 -> no spawn, gap stays 0. When slot1 clears, the spawn lands in slot1 on that tick.
- Speed ramp: run 600*4 ticks with RAMP_TICKS=600 -> speed goes 1→2→3→4 at ticks 600/1200/1800 and remains 4 at tick 2400.
- Game over and priority:
  - game_over_pulse with a tick in the same cycle -> FROZEN, positions unchanged; further ticks give no change.
  - game_start_pulse afterwards -> slots cleared, speed=1.
  - game_over and game_start in the same cycle while in RUN -> FROZEN.
